// File: rtl/pm_boot_loader.sv
// Boot loader: takes a 16-bit halfword stream, builds 32-bit instructions and writes them into
// program memory from address 0. The core stays in reset until the image checksum matches.
module pm_boot_loader #(
    parameter int PMA_SIZE = 16,
    parameter int PMD_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ext_vld,
    input  logic [15:0]         ext_dt,
    output logic                ext_rdy,
    output logic                ldr_pm_cslt,
    output logic                ldr_pm_wrb,
    output logic [PMA_SIZE-1:0] ldr_pm_add,
    output logic [PMD_SIZE-1:0] ldr_pm_dt,
    output logic                ldr_core_rst,
    output logic                ldr_done,
    output logic                ldr_err
);

    // Count width holds both the 16-bit header and the value 2**PMA_SIZE.
    localparam int CW = (PMA_SIZE + 1 > 17) ? PMA_SIZE + 1 : 17;
    localparam logic [CW-1:0] MAX_N = {{(CW-1){1'b0}}, 1'b1} << PMA_SIZE;

    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]          state;
    logic [2:0]          state_nx;
    logic [PMA_SIZE-1:0] idx;
    logic [PMA_SIZE:0]   idx_inc;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       hdr_n;
    logic [15:0]         sum;
    logic [15:0]         hi;
    logic                xfer;
    logic                rdy_nx;

    // A halfword moves only when the stream offers it and ext_rdy was already high this cycle.
    assign xfer    = ext_vld && ext_rdy;
    assign idx_inc = {1'b0, idx} + {{PMA_SIZE{1'b0}}, 1'b1};
    assign hdr_n   = CW'(ext_dt);

    always_comb begin
        state_nx = state;
        case (state)
            S_HDR: begin
                if (xfer) begin
                    if (ext_dt == 16'd0)
                        state_nx = S_CHK;
                    else if (hdr_n > MAX_N)
                        state_nx = S_ERR;
                    else
                        state_nx = S_HI;
                end
            end
            S_HI:  if (xfer) state_nx = S_LO;
            S_LO:  if (xfer) state_nx = S_WR;
            // Widened compare so N == 2**PMA_SIZE terminates even though idx wraps.
            S_WR:  state_nx = (CW'(idx_inc) == cnt) ? S_CHK : S_HI;
            S_CHK: begin
                if (xfer)
                    state_nx = (ext_dt == sum) ? S_DONE : S_ERR;
            end
            S_DONE: state_nx = S_DONE;
            S_ERR:  state_nx = S_ERR;
            default: state_nx = S_ERR;
        endcase
    end

    always_comb begin
        rdy_nx = 1'b0;
        case (state_nx)
            S_HDR, S_HI, S_LO, S_CHK: rdy_nx = 1'b1;
            default:                  rdy_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_HDR;
            idx          <= '0;
            cnt          <= '0;
            sum          <= '0;
            hi           <= '0;
            ext_rdy      <= 1'b0;
            ldr_pm_cslt  <= 1'b0;
            ldr_pm_wrb   <= 1'b0;
            ldr_pm_add   <= '0;
            ldr_pm_dt    <= '0;
            ldr_core_rst <= 1'b1;
            ldr_done     <= 1'b0;
            ldr_err      <= 1'b0;
        end else begin
            state   <= state_nx;
            ext_rdy <= rdy_nx;
            case (state)
                S_HDR: begin
                    if (xfer) begin
                        cnt <= hdr_n;
                        sum <= ext_dt;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi  <= ext_dt;
                        sum <= sum + ext_dt;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        ldr_pm_dt   <= PMD_SIZE'({hi, ext_dt});
                        ldr_pm_add  <= idx;
                        sum         <= sum + ext_dt;
                        ldr_pm_cslt <= 1'b1;
                        ldr_pm_wrb  <= 1'b1;
                    end
                end
                S_WR: begin
                    ldr_pm_cslt <= 1'b0;
                    ldr_pm_wrb  <= 1'b0;
                    idx         <= idx_inc[PMA_SIZE-1:0];
                end
                default: ;
            endcase
            if (state_nx == S_DONE) begin
                ldr_done     <= 1'b1;
                ldr_core_rst <= 1'b0;
            end
            if (state_nx == S_ERR)
                ldr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pm_boot_loader.sv
// Directed bench for pm_boot_loader: a full-size instance (a) and a PMA_SIZE=4 instance (b)
// share clock and reset; a negedge monitor keeps a program-memory model for each.
module tb_pm_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic [15:0] dt_a = '0, dt_b = '0;
    logic        rdy_a, cslt_a, wrb_a, crst_a, done_a, err_a;
    logic        rdy_b, cslt_b, wrb_b, crst_b, done_b, err_b;
    logic [15:0] add_a;
    logic [3:0]  add_b;
    logic [31:0] pdt_a, pdt_b;

    logic [31:0] pm_a [int];
    logic [31:0] pm_b [int];
    int          wr_a = 0, wr_b = 0;
    int          last_add_b = 0;
    int          n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    pm_boot_loader #(.PMA_SIZE(16), .PMD_SIZE(32)) dut_a (
        .clk(clk), .reset(reset), .ext_vld(vld_a), .ext_dt(dt_a), .ext_rdy(rdy_a),
        .ldr_pm_cslt(cslt_a), .ldr_pm_wrb(wrb_a), .ldr_pm_add(add_a), .ldr_pm_dt(pdt_a),
        .ldr_core_rst(crst_a), .ldr_done(done_a), .ldr_err(err_a)
    );

    pm_boot_loader #(.PMA_SIZE(4), .PMD_SIZE(32)) dut_b (
        .clk(clk), .reset(reset), .ext_vld(vld_b), .ext_dt(dt_b), .ext_rdy(rdy_b),
        .ldr_pm_cslt(cslt_b), .ldr_pm_wrb(wrb_b), .ldr_pm_add(add_b), .ldr_pm_dt(pdt_b),
        .ldr_core_rst(crst_b), .ldr_done(done_b), .ldr_err(err_b)
    );

    // cslt lasts exactly one cycle, so each negedge that sees it is one PM write.
    always @(negedge clk) begin
        if (cslt_a && wrb_a) begin
            pm_a[int'(add_a)] = pdt_a;
            wr_a++;
        end
        if (cslt_b && wrb_b) begin
            pm_b[int'(add_b)] = pdt_b;
            last_add_b = int'(add_b);
            wr_b++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        vld_a = 1'b0;
        vld_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pm_a.delete();
        pm_b.delete();
        wr_a = 0;
        wr_b = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one halfword; it is consumed at the posedge after a negedge that sees ext_rdy=1.
    task automatic send(input int sel, input logic [15:0] d);
        int n = 0;
        if (sel == 0) begin vld_a = 1'b1; dt_a = d; end
        else          begin vld_b = 1'b1; dt_b = d; end
        while (((sel == 0) ? rdy_a : rdy_b) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50)
            check("send_rdy", {31'd0, (sel == 0) ? rdy_a : rdy_b}, 32'd1);
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic wait_end(input int sel);
        int n = 0;
        while (n < 40 && ((sel == 0) ? (done_a | err_a) : (done_b | err_b)) !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("end_seen", {31'd0, (sel == 0) ? (done_a | err_a) : (done_b | err_b)}, 32'd1);
    endtask

    task automatic send_image1(input logic [15:0] chk, input bit gaps);
        logic [15:0] img [6];
        img[0] = 16'h0002; img[1] = 16'h1234; img[2] = 16'h5678;
        img[3] = 16'h9ABC; img[4] = 16'hDEF0; img[5] = chk;
        for (int i = 0; i < 6; i++) begin
            send(0, img[i]);
            if (gaps) idle((i == 1) ? 10 : int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy", {31'd0, rdy_a}, 32'd0);
        check("rst_cslt", {31'd0, cslt_a}, 32'd0);
        check("rst_wrb", {31'd0, wrb_a}, 32'd0);
        check("rst_add", {16'd0, add_a}, 32'd0);
        check("rst_dt", pdt_a, 32'd0);
        check("rst_core_rst", {31'd0, crst_a}, 32'd1);
        check("rst_done_err", {30'd0, done_a, err_a}, 32'd0);
        do_reset();

        // Test 1: two-instruction image, good checksum
        send_image1(16'hE25A, 1'b0);
        wait_end(0);
        check("t1_pm0", pm_a[0], 32'h12345678);
        check("t1_pm1", pm_a[1], 32'h9ABCDEF0);
        check("t1_writes", wr_a, 32'd2);
        check("t1_flags", {29'd0, done_a, crst_a, err_a}, 32'b100);
        idle(3);
        check("t1_rdy_after", {31'd0, rdy_a}, 32'd0);

        // Test 2: empty image
        do_reset();
        send(0, 16'h0000);
        send(0, 16'h0000);
        wait_end(0);
        check("t2_writes", wr_a, 32'd0);
        check("t2_flags", {29'd0, done_a, crst_a, err_a}, 32'b100);

        // Test 3: bad checksum
        do_reset();
        send_image1(16'hE25B, 1'b0);
        wait_end(0);
        check("t3_writes", wr_a, 32'd2);
        check("t3_pm1", pm_a[1], 32'h9ABCDEF0);
        check("t3_flags", {29'd0, done_a, crst_a, err_a}, 32'b011);
        idle(3);
        check("t3_rdy_after", {31'd0, rdy_a}, 32'd0);

        // Test 4: image 1 with stalls
        do_reset();
        send_image1(16'hE25A, 1'b1);
        wait_end(0);
        check("t4_pm0", pm_a[0], 32'h12345678);
        check("t4_pm1", pm_a[1], 32'h9ABCDEF0);
        check("t4_writes", wr_a, 32'd2);
        check("t4_flags", {29'd0, done_a, crst_a, err_a}, 32'b100);

        // Test 5: reset mid-instruction, then full replay
        do_reset();
        send(0, 16'h0002);
        send(0, 16'h1234);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_core", {31'd0, crst_a}, 32'd1);
        check("t5_rst_cslt", {31'd0, cslt_a}, 32'd0);
        check("t5_rst_rdy", {31'd0, rdy_a}, 32'd0);
        @(negedge clk);
        check("t5_no_write", wr_a, 32'd0);
        reset = 1'b0;
        send_image1(16'hE25A, 1'b0);
        wait_end(0);
        check("t5_pm0", pm_a[0], 32'h12345678);
        check("t5_pm1", pm_a[1], 32'h9ABCDEF0);
        check("t5_writes", wr_a, 32'd2);
        check("t5_done", {31'd0, done_a}, 32'd1);

        // Test 6a: PMA_SIZE=4, header 17 exceeds memory
        do_reset();
        send(1, 16'h0011);
        wait_end(1);
        check("t6_err", {29'd0, done_b, crst_b, err_b}, 32'b011);
        check("t6_err_writes", wr_b, 32'd0);

        // Test 6b: full 16-instruction image; hi=i, lo=A000+i, checksum 0x0100
        do_reset();
        send(1, 16'h0010);
        for (int i = 0; i < 16; i++) begin
            send(1, 16'(i));
            send(1, 16'hA000 + 16'(i));
        end
        send(1, 16'h0100);
        wait_end(1);
        check("t6_writes", wr_b, 32'd16);
        check("t6_last_add", last_add_b, 32'hF);
        check("t6_pm15", pm_b[15], 32'h000FA00F);
        check("t6_pm0", pm_b[0], 32'h0000A000);
        check("t6_flags", {29'd0, done_b, crst_b, err_b}, 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
